fibo_seq_gen: RTL and testbench
===============================

Name: fibo_seq_gen

Overview:
Parametrised Fibonacci sequence generator, successor to the free-running 5-bit series counter. Generates a programmable-length sequence from programmable seeds. Presents terms over a valid/ready stream and detects overflow, with selectable stop-or-wrap behaviour. Sits as a stimulus/data source feeding downstream stream consumers.

Parameters:
WIDTH, 16, term width in bits (min 2)
CNT_W, 8, width of term-count and index fields

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  begin a sequence; sampled only in IDLE
abort  in  1  cancel a running sequence; sampled in RUN
seed0  in  WIDTH  first term, latched on accepted start
seed1  in  WIDTH  second term, latched on accepted start
num_terms  in  CNT_W  terms to emit, latched on accepted start; 0 = none
wrap_mode  in  1  latched on accepted start; 1 = wrap modulo 2^WIDTH, 0 = stop on overflow
out_valid  out  1  term valid
out_ready  in  1  consumer ready
out_term  out  WIDTH  current term
out_idx  out  CNT_W  index of current term, first term = 0
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at sequence end
overflow  out  1  sticky per sequence; set when an overflowed term occurs (wrap) or the sequence truncates (stop)

Behaviour:
- Reset (rst=1 at a clk edge), highest priority, legal at any time: state=IDLE; all outputs 0; internal a, b, flags, counters cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, num_terms != 0:
  - Latch a=seed0, b=seed1, a_ovf=b_ovf=0, remaining=num_terms, mode, overflow=0.
  - Next cycle: RUN, out_valid=1, out_term=seed0, out_idx=0. Start-to-first-valid latency is 1 cycle.
- IDLE, start=1, num_terms=0: go to DONE. No valid is emitted; done pulses the following cycle.
- IDLE, start=0: remain in IDLE; out_valid=0.
- RUN:
  - out_term=a. out_term and out_idx are held stable while out_valid=1 and out_ready=0.
  - Handshake = out_valid & out_ready.
  - On each handshake, compute the sum a+b at WIDTH+1 bits, then update:
    - a<=b, a_ovf<=b_ovf
    - b<=sum[WIDTH-1:0], b_ovf<=sum[WIDTH] | a_ovf | b_ovf
    - out_idx+=1, remaining-=1
  - Handshake with remaining==1: go to DONE, out_valid=0 next cycle.
  - Stop mode, handshake with b_ovf=1 (the next term would be overflowed): go to DONE with overflow=1. The overflowed term is never presented.
  - Wrap mode: continue. overflow is set in the cycle a term with a_ovf=1 is first presented.
  - A term-count end and an overflow stop on the same handshake: go to DONE. overflow is set only if the overflowed term would have been within num_terms; under this rule it is not set.
  - abort=1: go to IDLE next cycle. out_valid=0 and busy=0 next cycle; no done pulse. abort outranks a simultaneous handshake, so that term counts as not consumed.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. overflow holds until the next accepted start or reset.
- start outside IDLE is ignored. abort outside RUN is ignored.
- busy = (state != IDLE).
- num_terms > 2^CNT_W-1 is unrepresentable; out_idx never wraps within a sequence.

Decomposition:
- Package fibo_pkg:
  - state enum (IDLE, RUN, DONE)
  - mode constants MODE_STOP=0, MODE_WRAP=1
- One sub-module, fibo_core: a/b registers, the WIDTH+1 adder and the a_ovf/b_ovf tracking, with load/advance controls.
- The top level holds the FSM, counters and the stream handshake.

Test Plan:
1. WIDTH=8, seeds 0/1, num_terms=10, out_ready=1 -> terms 0,1,1,2,3,5,8,13,21,34 on consecutive cycles, idx 0..9; done pulses 1 cycle after last handshake; overflow=0.
2. WIDTH=8, stop mode, seeds 0/1, num_terms=20 -> 14 terms ending at 233 (idx 13); done pulses with overflow=1; 377 is never presented.
3. WIDTH=8, wrap mode, same seeds, num_terms=16 -> idx 14 = 121 (377 mod 256), idx 15 = 98 (610 mod 256); overflow rises when idx 14 is presented; done after 16 terms.
4. Seeds 3/4, out_ready toggling 1,0,0,1 repeating -> out_term/out_idx stable during stalls; sequence 3,4,7,11,18 with no drops or duplicates.
5. num_terms=0 -> no out_valid; done pulses exactly once; busy high for one cycle.
6. Mid-RUN: abort at idx 3 -> IDLE with no done; rst at idx 5 of a new run -> all outputs 0 next cycle; start asserted during RUN -> ignored, sequence unchanged.

Source files
------------

// File: rtl/fibo_seq_gen_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
package fibo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/fibo_seq_gen_if.sv
// Valid/ready term stream produced by the Fibonacci generator.
interface fibo_seq_gen_if #(
    parameter int unsigned WIDTH = fibo_pkg::DEF_WIDTH,
    parameter int unsigned CNT_W = fibo_pkg::DEF_CNT_W
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_term;
    logic [CNT_W-1:0] out_idx;

    modport master (
        output out_valid,
        output out_term,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_term,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/fibo_seq_gen_core.sv
// Fibonacci datapath: a/b term registers, the WIDTH+1 adder and overflow tracking.
module fibo_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic [WIDTH-1:0] a,
    output logic             b_ovf
);

    logic [WIDTH-1:0] b;
    logic             a_ovf;
    logic [WIDTH:0]   sum;

    // Carry-out of the extended sum marks a term that no longer fits WIDTH bits
    always_comb begin
        sum = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    end

    // Overflow flags travel with their terms so a wrapped value stays marked
    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (load) begin
            a     <= seed0;
            b     <= seed1;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (advance) begin
            a     <= b;
            a_ovf <= b_ovf;
            b     <= sum[WIDTH-1:0];
            b_ovf <= sum[WIDTH] | a_ovf | b_ovf;
        end
    end

endmodule

// File: rtl/fibo_seq_gen.sv
// Programmable-length Fibonacci term source with stop-or-wrap overflow handling.
module fibo_seq_gen
    import fibo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             wrap_mode,
    fibo_seq_gen_if.master   strm,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    state_e           state_q;
    state_e           state_d;
    logic             out_valid_q;
    logic [CNT_W-1:0] out_idx_q;
    logic [CNT_W-1:0] remaining_q;
    logic             mode_q;
    logic             overflow_q;
    logic             done_q;
    logic             busy_q;

    logic             hs;
    logic             load;
    logic             advance;
    logic             set_ovf;
    logic             clr_ovf;

    logic [WIDTH-1:0] term_a;
    logic             next_ovf;

    fibo_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .seed0   (seed0),
        .seed1   (seed1),
        .a       (term_a),
        .b_ovf   (next_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls; abort outranks a same-cycle handshake
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        set_ovf = 1'b0;
        clr_ovf = 1'b0;
        hs      = out_valid_q & strm.out_ready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_ovf = 1'b1;
                    if (num_terms != '0) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    advance = 1'b1;
                    // Count end wins: an overflowed term past num_terms is not flagged
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (next_ovf) begin
                        set_ovf = 1'b1;
                        if (mode_q == MODE_STOP) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and sequence counters
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            remaining_q <= '0;
            mode_q      <= MODE_STOP;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);

            if (load) begin
                out_idx_q   <= '0;
                remaining_q <= num_terms;
                mode_q      <= wrap_mode;
            end else if (advance) begin
                out_idx_q   <= out_idx_q + CNT_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end

            if (clr_ovf) begin
                overflow_q <= 1'b0;
            end else if (set_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign strm.out_valid = out_valid_q;
    assign strm.out_term  = term_a;
    assign strm.out_idx   = out_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fibo_seq_gen.sv
// Directed bench for fibo_seq_gen: vector table of whole sequences plus abort/reset/start corner cases.
module tb_fibo_seq_gen;
    import fibo_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned C = 8;
    localparam int          MAX_CYC = 200;
    localparam int          NVEC = 5;

    typedef struct {
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        logic [C-1:0] n;
        logic         wr;
        logic [3:0]   rpat;
        int           exp_cnt;
        int           ovf_idx;
        logic         exp_ovf;
        int           exp_busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         wrap_mode;
    logic [W-1:0] seed0;
    logic [W-1:0] seed1;
    logic [C-1:0] num_terms;
    logic         busy;
    logic         done;
    logic         overflow;

    fibo_seq_gen_if #(.WIDTH(W), .CNT_W(C)) strm ();

    fibo_seq_gen #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .seed0     (seed0),
        .seed1     (seed1),
        .num_terms (num_terms),
        .wrap_mode (wrap_mode),
        .strm      (strm.master),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] acc_term[$];
    logic [C-1:0] acc_idx[$];
    logic         acc_ovf[$];
    int done_cnt, done_cyc, last_hs, first_valid, stall_err, valid_in_done, busy_cyc;

    vec_t vecs[NVEC];
    int   exp_terms[NVEC][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one sequence and record every accepted term until done settles
    task automatic run_seq(input vec_t v);
        logic         stall;
        logic         r;
        logic [W-1:0] pterm;
        logic [C-1:0] pidx;
        int           vcnt;
        acc_term.delete();
        acc_idx.delete();
        acc_ovf.delete();
        done_cnt = 0; done_cyc = -1; last_hs = -1; first_valid = -1;
        stall_err = 0; valid_in_done = 0; busy_cyc = 0;
        stall = 1'b0; pterm = '0; pidx = '0; vcnt = 0;
        @(negedge clk);
        seed0 = v.s0; seed1 = v.s1; num_terms = v.n; wrap_mode = v.wr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < MAX_CYC; cyc++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (strm.out_valid) valid_in_done++;
            end
            if (strm.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall && (strm.out_term !== pterm || strm.out_idx !== pidx)) stall_err++;
                r = v.rpat[2'(vcnt % 4)];
                vcnt++;
            end else begin
                r = 1'b0;
            end
            strm.out_ready = r;
            if (strm.out_valid && r) begin
                acc_term.push_back(strm.out_term);
                acc_idx.push_back(strm.out_idx);
                acc_ovf.push_back(overflow);
                last_hs = cyc;
            end
            stall = strm.out_valid && !r;
            pterm = strm.out_term;
            pidx  = strm.out_idx;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
        end
        strm.out_ready = 1'b0;
    endtask

    task automatic wait_idx(input logic [C-1:0] target, input string name);
        int n = 0;
        while (!(strm.out_valid === 1'b1 && strm.out_idx == target) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for idx %0d", name, target);
        end
    endtask

    initial begin
        int seen_done;

        vecs[0] = '{8'd0, 8'd1, 8'd10, MODE_STOP, 4'b1111, 10, -1, 1'b0, 11};
        vecs[1] = '{8'd0, 8'd1, 8'd20, MODE_STOP, 4'b1111, 14, -1, 1'b1, 15};
        vecs[2] = '{8'd0, 8'd1, 8'd16, MODE_WRAP, 4'b1111, 16, 14, 1'b1, 17};
        vecs[3] = '{8'd3, 8'd4, 8'd5,  MODE_STOP, 4'b1001, 5,  -1, 1'b0, 10};
        vecs[4] = '{8'd0, 8'd1, 8'd0,  MODE_STOP, 4'b1111, 0,  -1, 1'b0, 1};
        exp_terms[0] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 0, 0, 0, 0, 0, 0};
        exp_terms[1] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 0, 0};
        exp_terms[2] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
        exp_terms[3] = '{3, 4, 7, 11, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_terms[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; wrap_mode = 1'b0;
        seed0 = '0; seed1 = '0; num_terms = '0; strm.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(strm.out_valid), 32'(0));
        chk("reset out_term", 32'(strm.out_term), 32'(0));
        chk("reset out_idx", 32'(strm.out_idx), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset overflow", 32'(overflow), 32'(0));
        rst = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            run_seq(vecs[k]);
            chk($sformatf("v%0d count", k), 32'(acc_term.size()), 32'(vecs[k].exp_cnt));
            for (int i = 0; i < vecs[k].exp_cnt; i++) begin
                if (i < acc_term.size()) begin
                    chk($sformatf("v%0d term[%0d]", k, i), 32'(acc_term[i]), 32'(exp_terms[k][i]));
                    chk($sformatf("v%0d idx[%0d]", k, i), 32'(acc_idx[i]), 32'(i));
                    chk($sformatf("v%0d ovf[%0d]", k, i), 32'(acc_ovf[i]),
                        32'(vecs[k].ovf_idx >= 0 && i >= vecs[k].ovf_idx));
                end
            end
            chk($sformatf("v%0d done pulses", k), 32'(done_cnt), 32'(1));
            chk($sformatf("v%0d first valid cycle", k), 32'(first_valid),
                32'((vecs[k].n == '0) ? -1 : 1));
            if (vecs[k].n != '0)
                chk($sformatf("v%0d done latency", k), 32'(done_cyc - last_hs), 32'(1));
            chk($sformatf("v%0d stall stability", k), 32'(stall_err), 32'(0));
            chk($sformatf("v%0d valid during done", k), 32'(valid_in_done), 32'(0));
            chk($sformatf("v%0d busy cycles", k), 32'(busy_cyc), 32'(vecs[k].exp_busy));
            chk($sformatf("v%0d final overflow", k), 32'(overflow), 32'(vecs[k].exp_ovf));
        end

        // Abort at idx 3 with ready high: back to IDLE, no done, term not consumed
        @(negedge clk);
        seed0 = 8'd0; seed1 = 8'd1; num_terms = 8'd20; wrap_mode = MODE_STOP;
        start = 1'b1; strm.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(8'd3, "abort wait");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort out_valid", 32'(strm.out_valid), 32'(0));
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort out_idx", 32'(strm.out_idx), 32'(3));
        seen_done = int'(done);
        repeat (3) begin
            @(negedge clk);
            seen_done += int'(done);
        end
        chk("abort no done", 32'(seen_done), 32'(0));

        // start during RUN is ignored; reset mid-sequence clears everything
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(8'd2, "restart wait");
        chk("restart idx2 term", 32'(strm.out_term), 32'(1));
        seed0 = 8'd50; seed1 = 8'd60; num_terms = 8'd1; wrap_mode = MODE_WRAP; start = 1'b1;
        @(negedge clk);
        chk("ignored start idx", 32'(strm.out_idx), 32'(3));
        chk("ignored start term", 32'(strm.out_term), 32'(2));
        @(negedge clk);
        chk("ignored start term idx4", 32'(strm.out_term), 32'(3));
        @(negedge clk);
        chk("ignored start term idx5", 32'(strm.out_term), 32'(5));
        chk("ignored start busy", 32'(busy), 32'(1));
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun rst out_valid", 32'(strm.out_valid), 32'(0));
        chk("midrun rst out_term", 32'(strm.out_term), 32'(0));
        chk("midrun rst out_idx", 32'(strm.out_idx), 32'(0));
        chk("midrun rst busy", 32'(busy), 32'(0));
        chk("midrun rst done", 32'(done), 32'(0));
        chk("midrun rst overflow", 32'(overflow), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post rst idle", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
